// File: rtl/particle_feeder.sv
// Particle feeder: streams particle pairs from the dual-port store into the pusher pair,
// drains the pusher pipeline with noop beats, then waits for the pusher to report done.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | issuing store reads and forwarding particle pairs
// FLUSH     | emitting noop beats to drain the pushers
// WAIT_DONE | waiting for (or consuming a latched) pusher_done
module particle_feeder #(
   parameter int PADDR_W     = 16,
   parameter int PART_W      = 32,
   parameter int RD_LAT      = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int FLUSH_BEATS = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [31:0]             num_particles_i,
   input  logic                    stall_i,
   input  logic                    pusher_done_i,
   output logic                    mem_ren_o,
   output logic [1:0][PADDR_W-1:0] mem_raddr_o,
   input  logic [1:0][PART_W-1:0]  mem_rdata_i,
   output logic                    valid_o,
   output logic                    noop_o,
   output logic [1:0][PART_W-1:0]  particle_out_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IF_W  = $clog2(RD_LAT + 1);
   localparam int FB_W  = $clog2(FLUSH_BEATS + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH, ST_WAIT_DONE} state_t;

   state_t                   state_q, state_d;
   logic [32:0]              rem_q, rem_d;
   logic [PADDR_W-1:0]       addr_q, addr_d;
   logic                     odd_q, odd_d;
   logic [FB_W-1:0]          fb_q, fb_d;
   logic                     pend_q, pend_d;
   logic                     done_q, done_d;
   logic [RD_LAT-1:0]        rd_vld_q, rd_odd_q;
   logic [1:0][PART_W-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W:0]           wr_ptr_q, rd_ptr_q;
   logic                     out_vld_q, out_vld_d;
   logic                     out_noop_q, out_noop_d;
   logic [1:0][PART_W-1:0]   out_dat_q, out_dat_d;

   logic [32:0]              pairs_w;
   logic [PTR_W:0]           fifo_cnt;
   logic [IF_W-1:0]          inflight;
   logic                     credit_ok;
   logic                     issue, last_issue, push, pop;
   logic                     load_ok, emit, load_noop;
   logic [1:0][PART_W-1:0]   push_dat;

   assign pairs_w  = ({1'b0, num_particles_i} + 33'd1) >> 1;
   assign fifo_cnt = wr_ptr_q - rd_ptr_q;
   assign push     = rd_vld_q[RD_LAT-1];
   assign load_ok  = !out_vld_q || !stall_i;
   assign emit     = out_vld_q && !stall_i;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + IF_W'(rd_vld_q[i]);
   end

   assign credit_ok = (int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH;

   // Odd particle count: the final pair's slot 1 becomes the null particle.
   always_comb begin
      push_dat    = mem_rdata_i;
      if (rd_odd_q[RD_LAT-1]) push_dat[1] = '0;
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      addr_d     = addr_q;
      odd_d      = odd_q;
      fb_d       = fb_q;
      pend_d     = pend_q | pusher_done_i;
      done_d     = 1'b0;
      issue      = 1'b0;
      pop        = 1'b0;
      load_noop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               rem_d  = pairs_w;
               addr_d = '0;
               odd_d  = num_particles_i[0];
               pend_d = 1'b0;
               if (num_particles_i == 32'd0) begin
                  state_d = ST_FLUSH;
                  fb_d    = FB_W'(FLUSH_BEATS);
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            issue = (rem_q != 33'd0) && credit_ok;
            if (issue) begin
               rem_d  = rem_q - 33'd1;
               addr_d = addr_q + PADDR_W'(2);
            end
            pop = load_ok && (fifo_cnt != '0);
            if ((rem_q == 33'd0) && (inflight == '0) && (fifo_cnt == '0)) begin
               state_d = ST_FLUSH;
               fb_d    = FB_W'(FLUSH_BEATS);
            end
         end
         ST_FLUSH: begin
            if (load_ok) begin
               if (fb_q != '0) begin
                  load_noop = 1'b1;
                  fb_d      = fb_q - FB_W'(1);
               end else begin
                  state_d = ST_WAIT_DONE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (pusher_done_i || pend_q) begin
               done_d  = 1'b1;
               pend_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign last_issue = issue && (rem_q == 33'd1) && odd_q;

   // The output register holds a beat until a cycle with stall low carries it out.
   always_comb begin
      out_vld_d  = out_vld_q && !emit;
      out_noop_d = out_noop_q;
      out_dat_d  = out_dat_q;
      if (pop) begin
         out_vld_d  = 1'b1;
         out_noop_d = 1'b0;
         out_dat_d  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
      end else if (load_noop) begin
         out_vld_d  = 1'b1;
         out_noop_d = 1'b1;
         out_dat_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         addr_q     <= '0;
         odd_q      <= 1'b0;
         fb_q       <= '0;
         pend_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_vld_q   <= '0;
         rd_odd_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_vld_q  <= 1'b0;
         out_noop_q <= 1'b0;
         out_dat_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         addr_q     <= addr_d;
         odd_q      <= odd_d;
         fb_q       <= fb_d;
         pend_q     <= pend_d;
         done_q     <= done_d;
         out_vld_q  <= out_vld_d;
         out_noop_q <= out_noop_d;
         out_dat_q  <= out_dat_d;
         rd_vld_q[0] <= issue;
         rd_odd_q[0] <= last_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            rd_odd_q[i] <= rd_odd_q[i-1];
         end
         if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   assign mem_ren_o      = issue;
   assign mem_raddr_o[0] = issue ? addr_q : '0;
   assign mem_raddr_o[1] = issue ? (addr_q | PADDR_W'(1)) : '0;
   assign valid_o        = out_vld_q && !stall_i;
   assign noop_o         = out_noop_q && valid_o;
   assign particle_out_o = out_dat_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign done_o         = done_q;

endmodule

// File: tb/tb_particle_feeder.sv
// Bench for particle_feeder: a vector table of whole passes against a two-cycle store model,
// plus hand-written reset-abort and mid-pass start / early pusher_done sequences.
module tb_particle_feeder;

   localparam int FLUSH = 8;

   logic              clk, rst_n, start, stall, pusher_done;
   logic [31:0]       num;
   logic              mem_ren;
   logic [1:0][15:0]  mem_raddr;
   logic [1:0][31:0]  mem_rdata;
   logic              valid, noop, busy, done;
   logic [1:0][31:0]  particle_out;

   particle_feeder dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_particles_i(num),
      .stall_i(stall), .pusher_done_i(pusher_done), .mem_ren_o(mem_ren),
      .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata), .valid_o(valid),
      .noop_o(noop), .particle_out_o(particle_out), .busy_o(busy), .done_o(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pval(input logic [15:0] a);
      return {16'hC0DE, a};
   endfunction

   // Store model: data appears two cycles after the read strobe.
   logic              p1_ren, p2_ren;
   logic [1:0][15:0]  p1_a, p2_a;
   always @(posedge clk) begin
      p1_ren <= mem_ren;  p1_a <= mem_raddr;
      p2_ren <= p1_ren;   p2_a <= p1_a;
   end
   assign mem_rdata[0] = p2_ren ? pval(p2_a[0]) : 32'd0;
   assign mem_rdata[1] = p2_ren ? pval(p2_a[1]) : 32'd0;

   logic stall_rnd;
   always @(posedge clk) begin
      #1;
      stall = stall_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   int          cyc = 0, data_cnt = 0, noop_cnt = 0, ren_cnt = 0, viol_cnt = 0, pend_rd = 0;
   logic [63:0] beat_log [256];
   int          beat_cyc [256];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) pend_rd = 0;
      else begin
         if (noop && !valid) begin viol_cnt++; $display("monitor: noop without valid, cycle %0d", cyc); end
         if (valid) begin
            if (stall) begin viol_cnt++; $display("monitor: valid while stall high, cycle %0d", cyc); end
            if (noop) begin
               noop_cnt++;
               if (particle_out != '0) begin viol_cnt++; $display("monitor: noop with data %0h", particle_out); end
            end else begin
               beat_log[data_cnt % 256] = particle_out;
               beat_cyc[data_cnt % 256] = cyc;
               data_cnt++;
               pend_rd--;
            end
         end
         if (mem_ren) begin
            if (pend_rd >= (stall ? 5 : 4)) begin
               viol_cnt++;
               $display("monitor: read issued with %0d outstanding, cycle %0d", pend_rd, cyc);
            end
            pend_rd++;
            ren_cnt++;
         end
      end
   end

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   typedef struct {
      int n;
      bit rnd;
      int exp_pairs;
      int exp_lat;
      bit pd_at_start;
   } vec_t;

   task automatic run_pass(input vec_t v);
      int b_data, b_noop, b_ren, b_viol, lat, guard;
      logic [63:0] exp;
      b_data = data_cnt; b_noop = noop_cnt; b_ren = ren_cnt; b_viol = viol_cnt;
      @(negedge clk);
      stall_rnd = v.rnd; start = 1'b1; num = v.n; pusher_done = v.pd_at_start;
      @(posedge clk); #1;
      start = 1'b0; pusher_done = 1'b0;
      check("busy_after_start", busy, 1);
      if (v.exp_lat != 0) begin
         lat = 0;
         for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (valid && !noop) lat = i;
         end
         check("first_valid_latency", lat, v.exp_lat);
      end
      guard = 0;
      while ((noop_cnt - b_noop) < FLUSH && guard < 3000) begin @(posedge clk); guard++; end
      check("flush_wait_in_budget", guard < 3000, 1);
      stall_rnd = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("noop_beats", noop_cnt - b_noop, FLUSH);
      check("waiting_busy", busy, 1);
      check("no_early_done", done, 0);
      @(negedge clk); pusher_done = 1'b1;
      @(posedge clk); #1; pusher_done = 1'b0;
      check("done_pulse", done, 1);
      check("idle_after_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("data_beats", data_cnt - b_data, v.exp_pairs);
      check("read_strobes", ren_cnt - b_ren, v.exp_pairs);
      check("monitor_violations", viol_cnt - b_viol, 0);
      for (int j = 0; j < v.exp_pairs; j++) begin
         exp[31:0]  = pval(16'(2*j));
         exp[63:32] = (2*j + 1 < v.n) ? pval(16'(2*j + 1)) : 32'd0;
         check($sformatf("pair_%0d_n%0d", j, v.n), beat_log[(b_data + j) % 256], exp);
      end
      if (!v.rnd && v.exp_pairs > 1)
         check("back_to_back", beat_cyc[(b_data + v.exp_pairs - 1) % 256] - beat_cyc[b_data % 256],
               v.exp_pairs - 1);
   endtask

   vec_t vecs [6];
   int b_data, b_noop, b_ren, guard;
   vec_t v4;

   initial begin
      vecs[0] = '{n: 6,  rnd: 0, exp_pairs: 3,  exp_lat: 4, pd_at_start: 0};
      vecs[1] = '{n: 5,  rnd: 0, exp_pairs: 3,  exp_lat: 4, pd_at_start: 0};
      vecs[2] = '{n: 0,  rnd: 0, exp_pairs: 0,  exp_lat: 0, pd_at_start: 0};
      vecs[3] = '{n: 1,  rnd: 0, exp_pairs: 1,  exp_lat: 4, pd_at_start: 1};
      vecs[4] = '{n: 7,  rnd: 0, exp_pairs: 4,  exp_lat: 4, pd_at_start: 0};
      vecs[5] = '{n: 40, rnd: 1, exp_pairs: 20, exp_lat: 0, pd_at_start: 0};
      rst_n = 1'b1; start = 1'b0; num = '0; pusher_done = 1'b0; stall_rnd = 1'b0; stall = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("reset_valid", valid, 0);
      check("reset_busy", busy, 0);
      check("reset_ren", mem_ren, 0);
      check("reset_data", particle_out, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) run_pass(vecs[i]);

      // Reset mid-FETCH, then a clean short pass.
      b_data = data_cnt;
      @(negedge clk); start = 1'b1; num = 10;
      @(posedge clk); #1; start = 1'b0;
      guard = 0;
      while ((data_cnt - b_data) < 2 && guard < 100) begin @(negedge clk); #1; guard++; end
      check("reset_test_beats_seen", guard < 100, 1);
      check("still_busy_before_abort", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", valid, 0);
      check("abort_noop", noop, 0);
      check("abort_ren", mem_ren, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_data", particle_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      v4 = '{n: 4, rnd: 0, exp_pairs: 2, exp_lat: 4, pd_at_start: 0};
      run_pass(v4);

      // Second start mid-pass is ignored; pusher_done during FLUSH is honoured on WAIT_DONE entry.
      b_data = data_cnt; b_noop = noop_cnt; b_ren = ren_cnt;
      @(negedge clk); start = 1'b1; num = 6;
      @(posedge clk); #1; start = 1'b0;
      guard = 0;
      while ((data_cnt - b_data) < 1 && guard < 50) begin @(posedge clk); #1; guard++; end
      @(negedge clk); start = 1'b1; num = 100;
      @(posedge clk); #1; start = 1'b0;
      guard = 0;
      while ((noop_cnt - b_noop) < 2 && guard < 100) begin @(posedge clk); #1; guard++; end
      check("reached_flush", guard < 100, 1);
      @(negedge clk); pusher_done = 1'b1;
      @(posedge clk); #1; pusher_done = 1'b0;
      guard = 0;
      while (!done && guard < 50) begin @(posedge clk); #1; guard++; end
      check("early_done_honoured", done, 1);
      check("early_done_noops", noop_cnt - b_noop, FLUSH);
      check("ignored_start_beats", data_cnt - b_data, 3);
      check("ignored_start_reads", ren_cnt - b_ren, 3);
      @(posedge clk); #1;
      check("early_done_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/particle_feeder.md
Name: particle_feeder

Overview:
- Upstream stage of the dual-pusher: streams particles from the dual-port particle store into the pusher pair, two per beat.
- Uses valid/noop/particle pair and issues noop flush beats to drain the pusher pipeline.
- Honours backpressure from the scatterer and reports completion to the top-level sequencer once the pusher signals done.

Parameters:
- PADDR_W, 16, width of particle store address (per port)
- RD_LAT, 2, particle store read latency in cycles (fixed, no rvalid)
- FIFO_DEPTH, 4, output skid FIFO depth in pairs (power of two, >= RD_LAT+1)
- FLUSH_BEATS, 8, number of noop beats issued after the last particle pair

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a pass (ignored unless IDLE)
- num_particles  in  32  particle count, sampled on accepted start
- stall  in  1  scatterer backpressure; no beat may be emitted while high
- pusher_done  in  1  done from the pusher pair
- mem_ren  out  1  read strobe to the particle store (both ports)
- mem_raddr  out  2 x PADDR_W  port0 = 2k, port1 = 2k+1
- mem_rdata  in  2 x particle_t  read data, RD_LAT cycles after mem_ren
- valid  out  1  beat valid to the pusher
- noop  out  1  flush beat (qualified by valid)
- particle_out  out  2 x particle_t  particle pair to the pushers
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_ren, valid, noop, busy and done = 0; particle_out = '0; counters and FIFO cleared; in-flight reads discarded.
- Reset mid-pass aborts with no done pulse.
- pairs = ceil(num_particles/2), computed as (n+1)>>1 in 33 bits; pair index k counts 0..pairs-1.
- States:
  - IDLE: start -> FETCH (n>0) or FLUSH (n=0). Latch n; clear k.
  - FETCH: issue mem_ren with addresses 2k and 2k+1 when credit allows, then k++.
    - Credit: fifo_count + inflight < FIFO_DEPTH. inflight = reads issued whose data has not returned (0..RD_LAT).
    - RD_LAT cycles after issue, data is pushed to the FIFO unconditionally; the credit rule guarantees no overflow.
    - Go to FLUSH when k==pairs, inflight==0 and the FIFO is empty.
  - Output (in FETCH): if FIFO non-empty and stall=0, pop and drive valid=1, noop=0, particle_out = pair, all registered (one-cycle output register). Otherwise valid=0.
    - Minimum latency start -> first valid = RD_LAT+2 cycles.
    - Sustained throughput is 1 pair/cycle with stall low.
  - Odd n: final pair slot 1 is forced to all-zero particle_t, the null particle with zero weight. Port 1 address is still 2k+1 but its data is discarded.
  - FLUSH: emit FLUSH_BEATS beats with valid=1, noop=1, particle_out='0. Beats are counted only on cycles with stall=0. Then go to WAIT_DONE.
  - WAIT_DONE: on pusher_done=1, pulse done for one cycle and go to IDLE.
    - pusher_done arriving before WAIT_DONE is latched (sticky flag, cleared on start) and honoured on entry.
- start while busy: ignored, with no effect on counters.
- stall asserted: output holds valid=0 the following cycle; the FIFO retains data; reads continue until credit is exhausted. No beat is lost or duplicated.
- start and pusher_done in the same IDLE cycle: start wins, and the sticky flag is cleared.
- Address wrap: k*2 truncated to PADDR_W. num_particles > 2^PADDR_W is out of contract.

Test Plan:
- Reset mid-FETCH (n=10, after 2 beats) -> all outputs 0 within same cycle; a later start with n=4 gives a clean 2-pair pass.
- n=6, stall=0, RD_LAT=2, store holds particle i at address i -> beats (0,1),(2,3),(4,5) on 3 consecutive cycles; first valid 4 cycles after start; then 8 noop beats; done 1 cycle after pusher_done.
- n=5 -> third pair = (4, zero particle); exactly 3 non-noop beats.
- n=0 -> no mem_ren ever; 8 noop beats; done after pusher_done.
- n=40 with stall toggled pseudo-randomly (50%) -> exactly 20 data beats, in address order, no duplicates; mem_ren never issued when fifo_count+inflight==4; no valid during any stall-high cycle.
- pusher_done pulsed during FLUSH, and a second start mid-pass -> done fires on WAIT_DONE entry; the second start is ignored and counts are unchanged.
